multisim_axi_outstanding_limiter: RTL

MULTISIM_AXI_OUTSTANDING_LIMITER -- requirements
Module: multisim_axi_outstanding_limiter

---
 rtl/multisim_axi_outstanding_limiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/multisim_axi_outstanding_limiter.sv
// multisim_axi_outstanding_limiter
//
// Buffers the AW, W and AR channels of an AXI manager in independent
// DEPTH-entry FIFOs. It releases AW/AR to the subordinate only while fewer
// than MAX_OUTSTANDING writes/reads are in flight. Write completions are
// counted from the observed B handshake. Read completions are counted from
// the observed R handshake carrying rlast. W is never gated by the write
// limit.
//
// Ports
//   clk, rst                       single clock, synchronous active-high reset
//   s_aw/s_awvalid/s_awready       AW from the client
//   s_w/s_wlast/s_wvalid/s_wready  W from the client
//   s_ar/s_arvalid/s_arready       AR from the client
//   o_m_aw*, i_m_awready           AW to the subordinate
//   o_m_w*, i_m_wready             W to the subordinate
//   o_m_ar*, i_m_arready           AR to the subordinate
//   i_m_bvalid/i_m_bready          observed B handshake
//   i_m_rvalid/i_m_rready/i_m_rlast observed R handshake
//   o_wr_outstanding, o_rd_outstanding  current in-flight counts
//   o_stall_cnt                    only with MULTISIM_AXI_LIMITER_STATS_EN:
//                                  saturating count of cycles in which a
//                                  buffered AW/AR is held back by the limit

module multisim_axi_outstanding_limiter_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);

  // One extra pointer bit separates the full state from the empty state.
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{PW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[PW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
endmodule

module multisim_axi_outstanding_limiter #(
  parameter int AW_WIDTH        = 64,
  parameter int W_WIDTH         = 72,
  parameter int AR_WIDTH        = 64,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW_WIDTH-1:0] s_aw,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [W_WIDTH-1:0]  s_w,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [AR_WIDTH-1:0] s_ar,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [AW_WIDTH-1:0] o_m_aw,
  output logic                o_m_awvalid,
  input  logic                i_m_awready,
  output logic [W_WIDTH-1:0]  o_m_w,
  output logic                o_m_wlast,
  output logic                o_m_wvalid,
  input  logic                i_m_wready,
  output logic [AR_WIDTH-1:0] o_m_ar,
  output logic                o_m_arvalid,
  input  logic                i_m_arready,
  input  logic                i_m_bvalid,
  input  logic                i_m_bready,
  input  logic                i_m_rvalid,
  input  logic                i_m_rready,
  input  logic                i_m_rlast,
  output logic [7:0]          o_wr_outstanding,
  output logic [7:0]          o_rd_outstanding
`ifdef MULTISIM_AXI_LIMITER_STATS_EN
  ,
  output logic [31:0]         o_stall_cnt
`endif
);
  localparam logic [7:0] MAX_CNT = 8'(MAX_OUTSTANDING);

  // A simultaneous increment and decrement cancel. A decrement at zero is
  // ignored, so the count never wraps.
  function automatic logic [7:0] next_cnt(input logic [7:0] cnt, input logic inc,
                                          input logic dec);
    if (inc && !dec) return cnt + 8'd1;
    if (dec && !inc && cnt != 8'd0) return cnt - 8'd1;
    return cnt;
  endfunction

  logic                aw_push, aw_pop, aw_empty, aw_full;
  logic                w_push, w_pop, w_empty, w_full;
  logic                ar_push, ar_pop, ar_empty, ar_full;
  logic [AW_WIDTH-1:0] aw_head;
  logic [W_WIDTH:0]    w_head;
  logic [AR_WIDTH-1:0] ar_head;
  logic [7:0]          wr_cnt, rd_cnt;

  // Ready depends only on registered FIFO state (and rst), never on valid.
  assign s_awready = !rst && !aw_full;
  assign s_wready  = !rst && !w_full;
  assign s_arready = !rst && !ar_full;

  assign aw_push = s_awvalid && s_awready;
  assign w_push  = s_wvalid && s_wready;
  assign ar_push = s_arvalid && s_arready;

  assign o_m_awvalid = !rst && !aw_empty && (wr_cnt < MAX_CNT);
  assign o_m_wvalid  = !rst && !w_empty;
  assign o_m_arvalid = !rst && !ar_empty && (rd_cnt < MAX_CNT);

  // Payloads read as zero in reset and while empty, so stale memory contents never show.
  assign o_m_aw    = (!rst && !aw_empty) ? aw_head : '0;
  assign o_m_w     = (!rst && !w_empty) ? w_head[W_WIDTH-1:0] : '0;
  assign o_m_wlast = !rst && !w_empty && w_head[W_WIDTH];
  assign o_m_ar    = (!rst && !ar_empty) ? ar_head : '0;

  assign aw_pop = o_m_awvalid && i_m_awready;
  assign w_pop  = o_m_wvalid && i_m_wready;
  assign ar_pop = o_m_arvalid && i_m_arready;

  multisim_axi_outstanding_limiter_fifo #(.WIDTH(AW_WIDTH), .DEPTH(DEPTH)) u_aw_fifo (
    .clk(clk), .rst(rst), .push(aw_push), .push_data(s_aw), .pop(aw_pop),
    .head(aw_head), .empty(aw_empty), .full(aw_full));

  multisim_axi_outstanding_limiter_fifo #(.WIDTH(W_WIDTH + 1), .DEPTH(DEPTH)) u_w_fifo (
    .clk(clk), .rst(rst), .push(w_push), .push_data({s_wlast, s_w}), .pop(w_pop),
    .head(w_head), .empty(w_empty), .full(w_full));

  multisim_axi_outstanding_limiter_fifo #(.WIDTH(AR_WIDTH), .DEPTH(DEPTH)) u_ar_fifo (
    .clk(clk), .rst(rst), .push(ar_push), .push_data(s_ar), .pop(ar_pop),
    .head(ar_head), .empty(ar_empty), .full(ar_full));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= 8'd0;
      rd_cnt <= 8'd0;
    end else begin
      wr_cnt <= next_cnt(wr_cnt, aw_pop, i_m_bvalid && i_m_bready);
      rd_cnt <= next_cnt(rd_cnt, ar_pop, i_m_rvalid && i_m_rready && i_m_rlast);
    end
  end

  assign o_wr_outstanding = wr_cnt;
  assign o_rd_outstanding = rd_cnt;

`ifdef MULTISIM_AXI_LIMITER_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic        stall;
  logic [31:0] stall_cnt;

  assign stall = (!aw_empty && wr_cnt == MAX_CNT) || (!ar_empty && rd_cnt == MAX_CNT);

  always_ff @(posedge clk) begin
    if (rst)        stall_cnt <= 32'd0;
    else if (stall) stall_cnt <= sat_inc(stall_cnt);
  end

  assign o_stall_cnt = stall_cnt;
`else
  // Stall statistics are not built in this configuration.
`endif
endmodule
